mux_pipe_skid: RTL and testbench

- Parametrised N-way, WIDTH-bit select mux followed by a valid/ready pipeline register with a 2-entry skid buffer.
- Used between CPU pipeline stages, e.g. the operand-forwarding or writeback-source mux, where the selected result must be registered and must tolerate downstream stalls without combinational ready paths.
- Also carries the select index through with the data, for debug and hazard tracking.

---
 rtl/mux_pipe_skid_if.sv | 27 ++
 rtl/mux_pipe_skid.sv | 119 +++++++++++
 tb/tb_mux_pipe_skid.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_skid_if.sv
// Handshake bundle for mux_pipe_skid: upstream mux inputs, flush and the registered downstream side.
// master drives the inputs and consumes results; slave is the mux/skid block itself.
interface mux_pipe_skid_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
);
  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_pipe_skid.sv
// N-way select mux feeding a registered valid/ready stage with a one-beat skid entry.
// in_ready comes straight from a flop, so downstream stalls never reach upstream combinationally.
module mux_pipe_skid #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input logic            clk,
  input logic            rst_n,
  mux_pipe_skid_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_q;
  logic   in_xfer, out_xfer;
  logic   load_main, load_skid, skid_to_main;

  logic [WIDTH-1:0] mux_data_p0;
  logic [SEL_W-1:0] sel_p0;
  logic [WIDTH-1:0] main_data_p1, skid_data_p1;
  logic [SEL_W-1:0] main_sel_p1, skid_sel_p1;

  // Out-of-range selects fall back to input 0.
  function automatic logic [WIDTH-1:0] sel_word(input logic [N_IN*WIDTH-1:0] d,
                                                input logic [SEL_W-1:0]      s);
    sel_word = d[0 +: WIDTH];
    for (int k = 1; k < N_IN; k++) begin
      if (int'(s) == k) sel_word = d[k*WIDTH +: WIDTH];
    end
  endfunction

  // ---- stage p0: combinational select ----
  assign mux_data_p0 = sel_word(bus.in_data, bus.in_sel);
  assign sel_p0      = bus.in_sel;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          case ({in_xfer, out_xfer})
            2'b11: load_main = 1'b1;
            2'b10: begin
              state_d   = FULL;
              load_skid = 1'b1;
            end
            2'b01: state_d = EMPTY;
            default: state_d = BUSY;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            state_d      = BUSY;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // ---- stage p1: main/skid registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_p1 <= '0;
      main_sel_p1  <= '0;
      skid_data_p1 <= '0;
      skid_sel_p1  <= '0;
    end else begin
      if (load_main) begin
        main_data_p1 <= mux_data_p0;
        main_sel_p1  <= sel_p0;
      end else if (skid_to_main) begin
        main_data_p1 <= skid_data_p1;
        main_sel_p1  <= skid_sel_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= mux_data_p0;
        skid_sel_p1  <= sel_p0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_data_p1;
  assign bus.out_sel   = main_sel_p1;

endmodule

// File: tb/tb_mux_pipe_skid.sv
// Bench for mux_pipe_skid: three instances (4x32, 3x32, 8x16) checked every cycle against
// a two-deep FIFO model, plus literal expectations for the directed scenarios.
module tb_mux_pipe_skid;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_pipe_skid_if #(.WIDTH(32), .N_IN(4)) i4 ();
  mux_pipe_skid_if #(.WIDTH(32), .N_IN(3)) i3 ();
  mux_pipe_skid_if #(.WIDTH(16), .N_IN(8)) i8 ();

  mux_pipe_skid #(.WIDTH(32), .N_IN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  mux_pipe_skid #(.WIDTH(32), .N_IN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  mux_pipe_skid #(.WIDTH(16), .N_IN(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  // Model: per instance, a FIFO of capacity two holding the selected word and raw select.
  int          mcnt[3] = '{0, 0, 0};
  logic [31:0] mdat[3][2];
  logic [3:0]  msel[3][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic v, input int sel, input logic [127:0] din,
                            input logic fl, input logic ordy, input int n, input int w);
    logic        it, ot;
    int          idx;
    logic [31:0] wd;
    it = v && (mcnt[k] < 2);
    ot = (mcnt[k] > 0) && ordy;
    if (fl) begin
      mcnt[k] = 0;
    end else begin
      if (ot) begin
        mdat[k][0] = mdat[k][1];
        msel[k][0] = msel[k][1];
        mcnt[k]--;
      end
      if (it) begin
        idx = (sel < n) ? sel : 0;
        wd  = 32'(din >> (idx * w));
        if (w == 16) wd[31:16] = 16'h0;
        mdat[k][mcnt[k]] = wd;
        msel[k][mcnt[k]] = 4'(sel);
        mcnt[k]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
      end else begin
        model_step(0, i4.in_valid, int'(i4.in_sel), 128'(i4.in_data), i4.flush, i4.out_ready, 4, 32);
        model_step(1, i3.in_valid, int'(i3.in_sel), 128'(i3.in_data), i3.flush, i3.out_ready, 3, 32);
        model_step(2, i8.in_valid, int'(i8.in_sel), 128'(i8.in_data), i8.flush, i8.out_ready, 8, 16);
      end
    end
  end

  task automatic check_dut(input int k, input string nm, input logic rdy, input logic vld,
                           input logic [31:0] d, input logic [3:0] s);
    chk({nm, "_in_ready"}, 64'(rdy), 64'(mcnt[k] < 2));
    chk({nm, "_out_valid"}, 64'(vld), 64'(mcnt[k] > 0));
    if (!rst_n) begin
      chk({nm, "_rst_data"}, 64'(d), 64'h0);
      chk({nm, "_rst_sel"}, 64'(s), 64'h0);
    end else if (mcnt[k] > 0) begin
      chk({nm, "_out_data"}, 64'(d), 64'(mdat[k][0]));
      chk({nm, "_out_sel"}, 64'(s), 64'(msel[k][0]));
    end
  endtask

  logic        p_stall = 1'b0;
  logic [15:0] p_data;
  logic [2:0]  p_sel;

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check_dut(0, "d4", i4.in_ready, i4.out_valid, 32'(i4.out_data), 4'(i4.out_sel));
    check_dut(1, "d3", i3.in_ready, i3.out_valid, 32'(i3.out_data), 4'(i3.out_sel));
    check_dut(2, "d8", i8.in_ready, i8.out_valid, 32'(i8.out_data), 4'(i8.out_sel));
    if (p_stall && i8.out_valid)
      chk("d8_stall_hold", 64'({i8.out_sel, i8.out_data}), 64'({p_sel, p_data}));
    if (mcnt[2] == 2) chk("d8_rdy_in_full", 64'(i8.in_ready), 64'h0);
    p_stall = rst_n && i8.out_valid && !i8.out_ready && !i8.flush;
    p_data  = i8.out_data;
    p_sel   = i8.out_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i4.in_data = '0; i4.in_sel = '0; i4.in_valid = 1'b0; i4.flush = 1'b0; i4.out_ready = 1'b0;
    i3.in_data = '0; i3.in_sel = '0; i3.in_valid = 1'b0; i3.flush = 1'b0; i3.out_ready = 1'b0;
    i8.in_data = '0; i8.in_sel = '0; i8.in_valid = 1'b0; i8.flush = 1'b0; i8.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(i4.out_valid), 64'h0);
    chk("rst_in_ready", 64'(i4.in_ready), 64'h1);
    chk("rst_out_data", 64'(i4.out_data), 64'h0);
    rst_n = 1'b1;
    tick();

    // Streaming: one beat per cycle, each visible one edge after acceptance.
    i4.in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      i4.in_sel = 2'(s);
      tick();
      chk("stream_valid", 64'(i4.out_valid), 64'h1);
      chk("stream_data", 64'(i4.out_data), 64'h1000_0000 + 64'(s));
      chk("stream_sel", 64'(i4.out_sel), 64'(s));
    end
    i4.in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(i4.out_valid), 64'h0);

    // Backpressure: A parks in MAIN, B in SKID, then both drain in order.
    i4.in_data   = {32'h0, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'h0};
    i4.out_ready = 1'b0;
    i4.in_valid  = 1'b1;
    i4.in_sel    = 2'd1;
    tick();
    chk("bp_a_data", 64'(i4.out_data), 64'hAAAA_AAAA);
    chk("bp_a_rdy", 64'(i4.in_ready), 64'h1);
    i4.in_sel = 2'd2;
    tick();
    chk("bp_a_hold", 64'(i4.out_data), 64'hAAAA_AAAA);
    chk("bp_full_rdy", 64'(i4.in_ready), 64'h0);
    i4.in_valid = 1'b0;
    tick();
    chk("bp_a_hold2", 64'(i4.out_data), 64'hAAAA_AAAA);
    chk("bp_a_sel", 64'(i4.out_sel), 64'h1);
    i4.out_ready = 1'b1;
    tick();
    chk("bp_b_data", 64'(i4.out_data), 64'hBBBB_BBBB);
    chk("bp_b_sel", 64'(i4.out_sel), 64'h2);
    chk("bp_b_rdy", 64'(i4.in_ready), 64'h1);
    tick();
    chk("bp_empty", 64'(i4.out_valid), 64'h0);

    // Out-of-range select on the 3-input instance falls back to input 0.
    i3.in_data   = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    i3.in_sel    = 2'd3;
    i3.in_valid  = 1'b1;
    i3.out_ready = 1'b1;
    tick();
    chk("oor_data", 64'(i3.out_data), 64'hDEAD_BEEF);
    chk("oor_sel", 64'(i3.out_sel), 64'h3);
    i3.in_valid = 1'b0;
    tick();

    // Flush while FULL with a third beat offered.
    i4.in_data   = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    i4.out_ready = 1'b0;
    i4.in_valid  = 1'b1;
    i4.in_sel    = 2'd1;
    tick();
    i4.in_sel = 2'd2;
    tick();
    chk("fl_full_rdy", 64'(i4.in_ready), 64'h0);
    i4.flush  = 1'b1;
    i4.in_sel = 2'd3;
    tick();
    chk("fl_valid", 64'(i4.out_valid), 64'h0);
    chk("fl_rdy", 64'(i4.in_ready), 64'h1);
    i4.flush     = 1'b0;
    i4.in_valid  = 1'b0;
    i4.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_no_beats", 64'(i4.out_valid), 64'h0);
    end

    // Asynchronous reset between edges while FULL.
    i4.out_ready = 1'b0;
    i4.in_valid  = 1'b1;
    i4.in_sel    = 2'd0;
    tick();
    i4.in_sel = 2'd1;
    tick();
    chk("ar_full_rdy", 64'(i4.in_ready), 64'h0);
    i4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(i4.out_valid), 64'h0);
    chk("ar_data", 64'(i4.out_data), 64'h0);
    chk("ar_rdy", 64'(i4.in_ready), 64'h1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    i4.in_data   = {32'h0, 32'h5555_1234, 32'h0, 32'h0};
    i4.in_sel    = 2'd2;
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b1;
    tick();
    chk("ar_after_data", 64'(i4.out_data), 64'h5555_1234);
    chk("ar_after_sel", 64'(i4.out_sel), 64'h2);
    i4.in_valid = 1'b0;
    tick();

    // Randomized traffic on the 8x16 instance.
    for (int c = 0; c < 10000; c++) begin
      i8.in_valid  = ($urandom_range(0, 3) != 0);
      i8.out_ready = ($urandom_range(0, 2) != 0);
      i8.in_sel    = 3'($urandom_range(0, 7));
      i8.in_data   = {$urandom, $urandom, $urandom, $urandom};
      i8.flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    i8.in_valid  = 1'b0;
    i8.flush     = 1'b0;
    i8.out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 64'(i8.out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
